// File: rtl/sdram_capture_writer.sv
// ---------------------------------------------------------------------------
// sdram_capture_writer
//
// Captures ADC samples after an arm/trigger sequence, buffers them in a small
// FIFO and writes them to sequential SDRAM word addresses through the
// controller's Req/Ack host port. Controller busy periods are absorbed by the
// FIFO. Completion, dropped samples and protocol violations are reported.
//
// Ports:
//   Clk, Reset      clock (rising edge), asynchronous active-high reset
//   SampleIn/Valid  ADC sample stream
//   Arm             one-cycle pulse starting a job (latches BaseAddr, NumSamples)
//   Trigger         level; opens sample acceptance while armed
//   MemReq/WnR/Addr/Data  write request to the SDRAM controller
//   MemAck, MemBusy controller acknowledge pulse and busy indication
//   CaptureBusy     job in progress (ARMED, CAPTURE or DRAIN)
//   Done            job complete (level)
//   Overflow        sticky: a sample was dropped on a full FIFO
//   ProtoErr        sticky: MemAck seen without an outstanding request
//   SamplesWritten  acknowledged writes in this job
//   FifoLevel       stored FIFO entries (the entry held in MemData excluded)
// ---------------------------------------------------------------------------
module sdram_capture_writer #(
    parameter int FIFO_AW = 4,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 22
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] SampleIn,
    input  logic              SampleValid,
    input  logic              Arm,
    input  logic              Trigger,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [ADDR_W-1:0] NumSamples,
    output logic              MemReq,
    output logic              MemWnR,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemData,
    input  logic              MemAck,
    input  logic              MemBusy,
    output logic              CaptureBusy,
    output logic              Done,
    output logic              Overflow,
    output logic              ProtoErr,
    output logic [ADDR_W-1:0] SamplesWritten,
    output logic [FIFO_AW:0]  FifoLevel
);

    localparam int unsigned      DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] LVL_FULL = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] LVL_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0]  ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   num_q, num_d;
    logic [ADDR_W-1:0]   accepted_q, accepted_d;
    logic [ADDR_W-1:0]   written_q, written_d;
    logic                ovf_q, ovf_d;
    logic                proto_q, proto_d;
    logic [1:0]          guard_q, guard_d;
    logic                cool_q, cool_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]    level_q, level_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic pop;
    logic push;
    logic ack;
    logic accept_win;
    logic last_push;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        num_d      = num_q;
        accepted_d = accepted_q;
        written_d  = written_q;
        ovf_d      = ovf_q;
        proto_d    = proto_q;
        guard_d    = guard_q;
        cool_d     = 1'b0;
        req_d      = req_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;

        // Acks arriving in the first two cycles after reset belong to a
        // request that reset already abandoned; they must not flag an error.
        if (guard_q != 2'd2) begin
            guard_d = guard_q + 2'd1;
        end

        // cool_q enforces a second idle cycle after each ack so the request
        // rate never exceeds one write per three cycles.
        pop = (level_q != '0) && !req_q && !MemAck && !MemBusy && !cool_q;
        ack = MemAck && req_q;

        // Acceptance opens in the trigger cycle itself while ARMED.
        accept_win = ((state_q == S_ARMED && Trigger) || state_q == S_CAPTURE)
                     && (accepted_q != num_q);
        push       = accept_win && SampleValid && ((level_q != LVL_FULL) || pop);
        last_push  = push && ((accepted_q + ADDR_ONE) == num_q);

        if (accept_win && SampleValid && !push) begin
            ovf_d = 1'b1;
        end
        if (push) begin
            wr_ptr_d   = wr_ptr_q + PTR_ONE;
            accepted_d = accepted_q + ADDR_ONE;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            req_d    = 1'b1;
            addr_d   = base_q + written_q;
            data_d   = mem_q[rd_ptr_q];
        end
        if (ack) begin
            req_d     = 1'b0;
            written_d = written_q + ADDR_ONE;
            cool_d    = 1'b1;
        end
        if (MemAck && !req_q && guard_q == 2'd2) begin
            proto_d = 1'b1;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        case (state_q)
            S_IDLE, S_DONE: begin
                if (Arm) begin
                    base_d     = BaseAddr;
                    num_d      = NumSamples;
                    accepted_d = '0;
                    written_d  = '0;
                    ovf_d      = 1'b0;
                    proto_d    = 1'b0;
                    state_d    = (NumSamples == '0) ? S_DONE : S_ARMED;
                end
            end
            S_ARMED: begin
                if (Trigger) begin
                    state_d = last_push ? S_DRAIN : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (last_push) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (level_q == '0 && !req_q && written_q == accepted_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            num_q      <= '0;
            accepted_q <= '0;
            written_q  <= '0;
            ovf_q      <= 1'b0;
            proto_q    <= 1'b0;
            guard_q    <= 2'd0;
            cool_q     <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_q      <= num_d;
            accepted_q <= accepted_d;
            written_q  <= written_d;
            ovf_q      <= ovf_d;
            proto_q    <= proto_d;
            guard_q    <= guard_d;
            cool_q     <= cool_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and level.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= SampleIn;
        end
    end

    assign MemReq         = req_q;
    assign MemWnR         = req_q;
    assign MemAddr        = addr_q;
    assign MemData        = data_q;
    assign CaptureBusy    = (state_q == S_ARMED) || (state_q == S_CAPTURE) ||
                            (state_q == S_DRAIN);
    assign Done           = (state_q == S_DONE);
    assign Overflow       = ovf_q;
    assign ProtoErr       = proto_q;
    assign SamplesWritten = written_q;
    assign FifoLevel      = level_q;

endmodule

// File: tb/tb_sdram_capture_writer.sv
module tb_sdram_capture_writer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] SampleIn;
    logic        SampleValid;
    logic        Arm;
    logic        Trigger;
    logic [21:0] BaseAddr;
    logic [21:0] NumSamples;
    logic        MemReq;
    logic        MemWnR;
    logic [21:0] MemAddr;
    logic [15:0] MemData;
    logic        MemAck;
    logic        MemBusy;
    logic        CaptureBusy;
    logic        Done;
    logic        Overflow;
    logic        ProtoErr;
    logic [21:0] SamplesWritten;
    logic [4:0]  FifoLevel;

    int total = 0;
    int bad   = 0;

    // controller model knobs
    int ack_delay = 1;
    bit stray_ack = 1'b0;
    int age       = 0;

    // write monitor
    logic [21:0] log_addr[$];
    logic [15:0] log_data[$];
    int          max_level = 0;
    int          req_rises = 0;
    logic        req_prev  = 1'b0;

    sdram_capture_writer #(.FIFO_AW(4), .DATA_W(16), .ADDR_W(22)) dut (
        .Clk(Clk), .Reset(Reset),
        .SampleIn(SampleIn), .SampleValid(SampleValid),
        .Arm(Arm), .Trigger(Trigger),
        .BaseAddr(BaseAddr), .NumSamples(NumSamples),
        .MemReq(MemReq), .MemWnR(MemWnR), .MemAddr(MemAddr), .MemData(MemData),
        .MemAck(MemAck), .MemBusy(MemBusy),
        .CaptureBusy(CaptureBusy), .Done(Done), .Overflow(Overflow),
        .ProtoErr(ProtoErr), .SamplesWritten(SamplesWritten), .FifoLevel(FifoLevel)
    );

    always #5 Clk = ~Clk;

    // Controller: acks ack_delay cycles after first seeing MemReq, one-cycle pulse.
    initial begin
        MemAck = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            if (MemReq) age++;
            else age = 0;
            MemAck = 1'b0;
            if (stray_ack) begin
                MemAck    = 1'b1;
                stray_ack = 1'b0;
            end else if (MemReq && age == ack_delay + 1) begin
                MemAck = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clk);
            if (MemReq && MemAck) begin
                log_addr.push_back(MemAddr);
                log_data.push_back(MemData);
            end
            if (int'(FifoLevel) > max_level) max_level = int'(FifoLevel);
            if (MemReq && !req_prev) req_rises++;
            req_prev = MemReq;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        max_level = 0;
    endtask

    task automatic arm(input logic [21:0] base, input logic [21:0] num);
        Arm        = 1'b1;
        BaseAddr   = base;
        NumSamples = num;
        tick();
        Arm = 1'b0;
    endtask

    task automatic send(input logic [15:0] d);
        SampleIn    = d;
        SampleValid = 1'b1;
        tick();
        SampleValid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !Done; i++) tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick(); tick();
        total++;
        if ({MemReq, MemWnR, CaptureBusy, Done, Overflow, ProtoErr} !== 6'b0 ||
            SamplesWritten !== 22'd0 || FifoLevel !== 5'd0) begin
            bad++;
            $display("FAIL reset_state: req=%b done=%b busy=%b ovf=%b perr=%b sw=%0d lvl=%0d, required all 0",
                     MemReq, Done, CaptureBusy, Overflow, ProtoErr, SamplesWritten, FifoLevel);
        end
        Reset = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_basic();
        logic [21:0] ea;
        logic [15:0] ed;
        clear_log();
        ack_delay = 1;
        arm(22'h000100, 22'd4);
        total++;
        if (CaptureBusy !== 1'b1) begin
            bad++; $display("FAIL basic_armed_busy: got %b required 1", CaptureBusy);
        end
        Trigger = 1'b1;
        for (int i = 0; i < 4; i++) send(16'hA000 + 16'(i));
        Trigger = 1'b0;
        wait_done(100);
        total++;
        if (Done !== 1'b1) begin
            bad++; $display("FAIL basic_done: got %b required 1", Done);
        end
        total++;
        if (log_addr.size() != 4) begin
            bad++; $display("FAIL basic_count: got %0d writes required 4", log_addr.size());
        end
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            ea = 22'h000100 + 22'(i);
            ed = 16'hA000 + 16'(i);
            total++;
            if (log_addr[i] !== ea || log_data[i] !== ed) begin
                bad++;
                $display("FAIL basic_write%0d: got %h/%h required %h/%h", i, log_addr[i], log_data[i], ea, ed);
            end
        end
        total++;
        if (SamplesWritten !== 22'd4 || Overflow !== 1'b0 || CaptureBusy !== 1'b0) begin
            bad++;
            $display("FAIL basic_final: sw=%0d ovf=%b busy=%b required 4/0/0", SamplesWritten, Overflow, CaptureBusy);
        end
    endtask

    task automatic test_trigger_boundary();
        clear_log();
        arm(22'h000200, 22'd2);
        for (int i = 0; i < 3; i++) send(16'hBBBB);
        total++;
        if (FifoLevel !== 5'd0 || MemReq !== 1'b0) begin
            bad++; $display("FAIL trig_armed_ignore: lvl=%0d req=%b required 0/0", FifoLevel, MemReq);
        end
        Trigger = 1'b1;
        send(16'hC000);
        Trigger = 1'b0;
        send(16'hC001);
        wait_done(100);
        total++;
        if (Done !== 1'b1 || log_addr.size() != 2) begin
            bad++; $display("FAIL trig_done: done=%b writes=%0d required 1/2", Done, log_addr.size());
        end else begin
            total++;
            if (log_addr[0] !== 22'h000200 || log_data[0] !== 16'hC000 ||
                log_addr[1] !== 22'h000201 || log_data[1] !== 16'hC001) begin
                bad++;
                $display("FAIL trig_writes: got %h/%h %h/%h required 000200/c000 000201/c001",
                         log_addr[0], log_data[0], log_addr[1], log_data[1]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [21:0] ea;
        logic [15:0] ed;
        clear_log();
        MemBusy = 1'b1;
        arm(22'h000000, 22'd20);
        Trigger = 1'b1;
        for (int i = 0; i < 20; i++) send(16'hD000 + 16'(i));
        Trigger = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        total++;
        if (FifoLevel !== 5'd16 || Overflow !== 1'b1 || log_addr.size() != 0) begin
            bad++;
            $display("FAIL ovf_busy: lvl=%0d ovf=%b writes=%0d required 16/1/0", FifoLevel, Overflow, log_addr.size());
        end
        MemBusy = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        for (int i = 0; i < 4; i++) send(16'hE000 + 16'(i));
        wait_done(400);
        total++;
        if (Done !== 1'b1 || SamplesWritten !== 22'd20 || log_addr.size() != 20) begin
            bad++;
            $display("FAIL ovf_done: done=%b sw=%0d writes=%0d required 1/20/20", Done, SamplesWritten, log_addr.size());
        end
        total++;
        if (max_level != 16 || Overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_peak: peak=%0d ovf=%b required 16/1", max_level, Overflow);
        end
        for (int i = 0; i < 20 && i < log_addr.size(); i++) begin
            ea = 22'(i);
            ed = (i < 16) ? 16'hD000 + 16'(i) : 16'hE000 + 16'(i - 16);
            total++;
            if (log_addr[i] !== ea || log_data[i] !== ed) begin
                bad++;
                $display("FAIL ovf_write%0d: got %h/%h required %h/%h", i, log_addr[i], log_data[i], ea, ed);
            end
        end
    endtask

    task automatic test_wrap_zero();
        int snap;
        clear_log();
        arm(22'h3FFFFE, 22'd3);
        Trigger = 1'b1;
        send(16'h1111); send(16'h2222); send(16'h3333);
        Trigger = 1'b0;
        wait_done(100);
        total++;
        if (Done !== 1'b1 || log_addr.size() != 3) begin
            bad++; $display("FAIL wrap_done: done=%b writes=%0d required 1/3", Done, log_addr.size());
        end else begin
            total++;
            if (log_addr[0] !== 22'h3FFFFE || log_addr[1] !== 22'h3FFFFF || log_addr[2] !== 22'h000000 ||
                log_data[0] !== 16'h1111 || log_data[1] !== 16'h2222 || log_data[2] !== 16'h3333) begin
                bad++;
                $display("FAIL wrap_addr: got %h %h %h required 3ffffe 3fffff 000000",
                         log_addr[0], log_addr[1], log_addr[2]);
            end
        end
        snap = req_rises;
        arm(22'h000055, 22'd0);
        total++;
        if (Done !== 1'b1 || CaptureBusy !== 1'b0 || SamplesWritten !== 22'd0) begin
            bad++;
            $display("FAIL zero_len: done=%b busy=%b sw=%0d required 1/0/0", Done, CaptureBusy, SamplesWritten);
        end
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (req_rises != snap || MemReq !== 1'b0) begin
            bad++; $display("FAIL zero_noreq: new requests=%0d required 0", req_rises - snap);
        end
    endtask

    task automatic test_held_request();
        bit stable;
        clear_log();
        ack_delay = 10;
        arm(22'h000040, 22'd1);
        Trigger = 1'b1;
        send(16'h7777);
        Trigger = 1'b0;
        for (int i = 0; i < 50 && !MemReq; i++) tick();
        MemBusy = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (MemReq !== 1'b1 || MemWnR !== 1'b1 || MemAddr !== 22'h000040 || MemData !== 16'h7777) stable = 1'b0;
        end
        total++;
        if (stable !== 1'b1) begin
            bad++;
            $display("FAIL held_stable: req=%b addr=%h data=%h required held 1/000040/7777", MemReq, MemAddr, MemData);
        end
        MemBusy = 1'b0;
        wait_done(100);
        total++;
        if (Done !== 1'b1 || SamplesWritten !== 22'd1 || ProtoErr !== 1'b0) begin
            bad++;
            $display("FAIL held_done: done=%b sw=%0d perr=%b required 1/1/0", Done, SamplesWritten, ProtoErr);
        end
        stray_ack = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (ProtoErr !== 1'b1) begin
            bad++; $display("FAIL proto_err: got %b required 1", ProtoErr);
        end
        ack_delay = 1;
    endtask

    task automatic test_reset_mid_drain();
        clear_log();
        ack_delay = 10;
        arm(22'h000300, 22'd4);
        Trigger = 1'b1;
        for (int i = 0; i < 4; i++) send(16'h5500 + 16'(i));
        Trigger = 1'b0;
        for (int i = 0; i < 50 && !MemReq; i++) tick();
        total++;
        if (MemReq !== 1'b1 || CaptureBusy !== 1'b1) begin
            bad++; $display("FAIL rst_pre: req=%b busy=%b required 1/1", MemReq, CaptureBusy);
        end
        #2;
        Reset = 1'b1;
        #1;
        total++;
        if (MemReq !== 1'b0 || CaptureBusy !== 1'b0 || FifoLevel !== 5'd0 || SamplesWritten !== 22'd0) begin
            bad++;
            $display("FAIL rst_async: req=%b busy=%b lvl=%0d sw=%0d required 0/0/0/0",
                     MemReq, CaptureBusy, FifoLevel, SamplesWritten);
        end
        tick(); tick();
        Reset = 1'b0;
        ack_delay = 1;
        tick(); tick(); tick();
        clear_log();
        arm(22'h000500, 22'd2);
        Trigger = 1'b1;
        send(16'h9001);
        send(16'h9002);
        Trigger = 1'b0;
        wait_done(100);
        total++;
        if (Done !== 1'b1 || SamplesWritten !== 22'd2 || ProtoErr !== 1'b0 || Overflow !== 1'b0 ||
            log_addr.size() != 2) begin
            bad++;
            $display("FAIL rst_clean_job: done=%b sw=%0d perr=%b ovf=%b writes=%0d required 1/2/0/0/2",
                     Done, SamplesWritten, ProtoErr, Overflow, log_addr.size());
        end else begin
            total++;
            if (log_addr[0] !== 22'h000500 || log_data[0] !== 16'h9001 ||
                log_addr[1] !== 22'h000501 || log_data[1] !== 16'h9002) begin
                bad++;
                $display("FAIL rst_clean_writes: got %h/%h %h/%h required 000500/9001 000501/9002",
                         log_addr[0], log_data[0], log_addr[1], log_data[1]);
            end
        end
    endtask

    initial begin
        Reset       = 1'b1;
        SampleIn    = '0;
        SampleValid = 1'b0;
        Arm         = 1'b0;
        Trigger     = 1'b0;
        BaseAddr    = '0;
        NumSamples  = '0;
        MemBusy     = 1'b0;
        test_reset();
        test_basic();
        test_trigger_boundary();
        test_overflow();
        test_wrap_zero();
        test_held_request();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_capture_writer.md
Name: sdram_capture_writer

Overview:
Client on the host side of the SDRAM controller's Req/Ack port. It captures ADC samples after an arm and trigger sequence, buffers them in a small FIFO, and writes them to sequential SDRAM word addresses starting at a programmed base. It absorbs the controller's busy periods (init, refresh) and reports completion, overflow and protocol errors.

Parameters:
FIFO_AW, 4, log2 of FIFO depth (depth 16)
DATA_W, 16, sample and SDRAM word width
ADDR_W, 22, SDRAM word address width (bank:col:row packing is owned by the controller)

Ports:
Clk  in  1  system clock; all logic on rising edge
Reset  in  1  asynchronous, active-high reset
SampleIn  in  DATA_W  ADC sample
SampleValid  in  1  SampleIn valid this cycle
Arm  in  1  one-cycle pulse that starts a capture job
Trigger  in  1  level; starts acceptance while ARMED
BaseAddr  in  ADDR_W  first write address, latched on Arm
NumSamples  in  ADDR_W  samples to capture, latched on Arm
MemReq  out  1  request to controller
MemWnR  out  1  write-not-read; always 1 while MemReq=1
MemAddr  out  ADDR_W  write address
MemData  out  DATA_W  write data
MemAck  in  1  controller acknowledge; one-cycle pulse
MemBusy  in  1  controller busy
CaptureBusy  out  1  job in progress (ARMED, CAPTURE or DRAIN)
Done  out  1  level; job complete
Overflow  out  1  sticky; at least one sample dropped
ProtoErr  out  1  sticky; MemAck seen with MemReq=0
SamplesWritten  out  ADDR_W  writes acknowledged in this job
FifoLevel  out  FIFO_AW+1  current FIFO occupancy

Behaviour:
- Reset (async): all outputs 0, state IDLE, FIFO empty, counters 0. Reset asserted mid-write drops MemReq immediately. A pending controller Ack after reset release is ignored and does not set ProtoErr in the first 2 cycles.
- States: IDLE, ARMED, CAPTURE, DRAIN, DONE.
- IDLE/DONE, Arm=1:
  - Latch BaseAddr and NumSamples.
  - Clear Done, Overflow, ProtoErr, SamplesWritten and the accepted count.
  - If NumSamples=0, go to DONE next cycle with Done=1. Otherwise go to ARMED.
- Arm in ARMED, CAPTURE or DRAIN is ignored.
- ARMED: samples are ignored. In the first cycle with Trigger=1, go to CAPTURE. A sample with SampleValid=1 in that same cycle is accepted as sample 0.
- CAPTURE:
  - Each SampleValid=1 pushes SampleIn into the FIFO.
  - A push is accepted if FifoLevel < depth, or if a pop occurs in the same cycle.
  - If the FIFO is full with no pop, the sample is dropped and Overflow is set. Dropped samples are not counted and do not consume an address.
  - When the accepted count reaches NumSamples, go to DRAIN. Further samples are ignored with no Overflow.
- Writer (runs in every state):
  - Start condition: FIFO non-empty, MemReq=0, MemAck=0 and MemBusy=0 sampled.
  - On start, pop the FIFO head into MemData, set MemAddr = BaseAddr + SamplesWritten (mod 2^ADDR_W, wraps silently), and assert MemReq=1 with MemWnR=1 on the next edge.
  - MemReq, MemAddr and MemData are held stable until MemAck=1 is sampled, regardless of MemBusy.
  - On the edge that samples MemAck=1: MemReq goes to 0 and SamplesWritten increments.
  - MemReq stays low for at least 1 cycle between requests. Maximum throughput is 1 write per 3 cycles.
- MemAck=1 while MemReq=0 sets ProtoErr and is otherwise ignored.
- DRAIN: when FIFO empty, MemReq=0 and SamplesWritten = accepted count, go to DONE. Done=1, CaptureBusy=0.
- CaptureBusy=1 exactly in ARMED, CAPTURE and DRAIN.
- FifoLevel counts entries stored; a popped entry held in MemData is not counted.

Test Plan:
- Basic job: Reset, Base=0x000100, Num=4, Trigger, 4 samples 0xA000..0xA003 with controller acking 1 cycle after Req -> writes 0x100..0x103 with matching data in order; Done=1, SamplesWritten=4, Overflow=0.
- Trigger boundary: samples during ARMED ignored; sample valid in the Trigger cycle = first write at BaseAddr.
- Overflow: MemBusy held 1 for 40 cycles during CAPTURE, 20 consecutive samples, Num=20 -> 16 buffered, Overflow=1, FifoLevel peaks at 16. After busy releases, 16 writes; job continues accepting until 20 accepted.
- Wrap and zero length: Base=0x3FFFFE, Num=3 -> addresses 0x3FFFFE, 0x3FFFFF, 0x000000. A separate Arm with Num=0 -> Done=1 within 2 cycles, no MemReq.
- Held request: MemBusy=1 while MemReq is already 1, Ack delayed 10 cycles -> MemReq, MemAddr and MemData are constant for all 10 cycles. A stray MemAck with MemReq=0 -> ProtoErr=1.
- Async reset mid-DRAIN with MemReq=1 -> MemReq=0 without a clock edge. A following Arm runs a clean job.
